// File: rtl/pipe_scheduler.sv
// pipe_scheduler: ring of scrolling pipe records, current-pipe edge mux,
// pass detection and a saturating 4-digit BCD score for the flappy datapath.
module pipe_scheduler #(
  parameter int unsigned NUM_PIPES    = 3,
  parameter int unsigned PIPE_W       = 60,
  parameter int unsigned PIPE_SPACING = 240,
  parameter int unsigned INIT_X       = 400,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned GAP_MIN      = 60,
  parameter int unsigned GAP_H        = 120,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Q_Initial,
  input  logic        Q_Check,
  input  logic        Q_Lose,
  input  logic        Frame_Tick,
  input  logic [9:0]  Bird_X_L,
  output logic [9:0]  X_Edge_Left,
  output logic [9:0]  X_Edge_Right,
  output logic [9:0]  Y_Edge_Top,
  output logic [9:0]  Y_Edge_Bottom,
  output logic [1:0]  Cur_Pipe,
  input  logic [1:0]  Pipe_Sel,
  output logic [9:0]  Pipe_X,
  output logic [9:0]  Pipe_Gap_Top,
  output logic [15:0] Score_BCD,
  output logic        Pass_Pulse
);

  localparam int unsigned IW  = (NUM_PIPES > 2) ? 2 : 1;
  localparam logic [2:0]  NP3 = 3'(NUM_PIPES);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_LOAD} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;
  logic   w_load;

  logic [7:0]  r_lfsr;
  logic        w_lfsr_fb;

  logic [9:0]  r_x [NUM_PIPES];
  logic [9:0]  r_g [NUM_PIPES];
  logic [9:0]  w_x_nxt [NUM_PIPES];
  logic [9:0]  w_g_nxt [NUM_PIPES];
  logic [NUM_PIPES-1:0] w_retire;

  logic [1:0]  r_cur;
  logic [15:0] r_score;
  logic        r_pass;

  logic [IW-1:0] w_cur_idx;
  logic [9:0]    w_cur_x;
  logic [9:0]    w_cur_g;
  logic [10:0]   w_cur_right;
  logic          w_cur_retire;
  logic          w_pass;
  logic          w_advance;
  logic [1:0]    w_cur_inc;

  function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (carry) begin
          if (res[d*4 +: 4] == 4'd9) begin
            res[d*4 +: 4] = 4'd0;
          end else begin
            res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  // Game-state FSM; Q inputs resolved with priority Lose > Initial > Check.
  always_ff @(posedge Clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE: if (Q_Check && !Q_Lose && !Q_Initial) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_run = 1'b1;
        if (Q_Lose) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: if (Q_Initial && !Q_Lose) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; free-running, reloaded only by reset.
  always_comb w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge Clk) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
    localparam int unsigned PREV = (gi + NUM_PIPES - 1) % NUM_PIPES;
    localparam logic [9:0]  X0   = 10'(INIT_X + gi * PIPE_SPACING);
    localparam logic [9:0]  G0   = 10'(GAP_MIN + 64 * gi);

    assign w_retire[gi] = (r_x[gi] <= 10'(SPEED));
    // Only one pipe retires per tick, so the predecessor's post-move value
    // is simply r_x[PREV] - SPEED; both offsets fold into one constant.
    assign w_x_nxt[gi]  = w_retire[gi] ? (r_x[PREV] + 10'(PIPE_SPACING - SPEED))
                                       : (r_x[gi] - 10'(SPEED));
    assign w_g_nxt[gi]  = w_retire[gi] ? (10'(GAP_MIN) + {2'b00, r_lfsr}) : r_g[gi];

    always_ff @(posedge Clk) begin
      if (!reset || w_load) begin
        r_x[gi] <= X0;
        r_g[gi] <= G0;
      end else if (w_run && Frame_Tick) begin
        r_x[gi] <= w_x_nxt[gi];
        r_g[gi] <= w_g_nxt[gi];
      end
    end
  end

  assign w_cur_idx    = r_cur[IW-1:0];
  assign w_cur_x      = r_x[w_cur_idx];
  assign w_cur_g      = r_g[w_cur_idx];
  assign w_cur_retire = w_retire[w_cur_idx];
  assign w_cur_right  = {1'b0, w_cur_x} + 11'(PIPE_W);

  // Pass compares pre-move values, so a same-cycle tick does not affect it.
  assign w_pass    = w_run && ({1'b0, Bird_X_L} > w_cur_right);
  assign w_advance = w_pass || (w_run && Frame_Tick && w_cur_retire);
  assign w_cur_inc = (r_cur == 2'(NUM_PIPES - 1)) ? 2'd0 : (r_cur + 2'd1);

  always_ff @(posedge Clk) begin
    if (!reset || w_load) begin
      r_cur   <= '0;
      r_score <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_pass <= w_pass;
      if (w_pass)    r_score <= f_bcd_inc(r_score);
      if (w_advance) r_cur   <= w_cur_inc;
    end
  end

  always_comb begin
    Pipe_X       = '0;
    Pipe_Gap_Top = '0;
    if ({1'b0, Pipe_Sel} < NP3) begin
      Pipe_X       = r_x[Pipe_Sel[IW-1:0]];
      Pipe_Gap_Top = r_g[Pipe_Sel[IW-1:0]];
    end
  end

  assign X_Edge_Left   = w_cur_x;
  assign X_Edge_Right  = w_cur_right[9:0];
  assign Y_Edge_Top    = w_cur_g;
  assign Y_Edge_Bottom = w_cur_g + 10'(GAP_H);
  assign Cur_Pipe      = r_cur;
  assign Score_BCD     = r_score;
  assign Pass_Pulse    = r_pass;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: random frame-tick spacing checked against an
// integer model of the pipe ring, game mode, LFSR and decimal score.
module tb_pipe_scheduler;

  localparam int NP     = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_LOAD = 3;

  logic        Clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        Q_Initial  = 1'b0;
  logic        Q_Check    = 1'b0;
  logic        Q_Lose     = 1'b0;
  logic        Frame_Tick = 1'b0;
  logic [9:0]  Bird_X_L   = '0;
  logic [1:0]  Pipe_Sel   = '0;
  logic [9:0]  X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom;
  logic [9:0]  Pipe_X, Pipe_Gap_Top;
  logic [1:0]  Cur_Pipe;
  logic [15:0] Score_BCD;
  logic        Pass_Pulse;

  int total = 0;
  int bad   = 0;

  int m_x [NP];
  int m_g [NP];
  int m_cur   = 0;
  int m_score = 0;
  int m_lfsr  = 0;
  int m_mode  = M_IDLE;
  int m_pulse = 0;
  int n_ticks = 0;

  pipe_scheduler #(
    .NUM_PIPES(3), .PIPE_W(60), .PIPE_SPACING(240), .INIT_X(400),
    .SPEED(2), .GAP_MIN(60), .GAP_H(120), .LFSR_SEED(8'hA5)
  ) dut (
    .Clk(Clk), .reset(reset), .Q_Initial(Q_Initial), .Q_Check(Q_Check),
    .Q_Lose(Q_Lose), .Frame_Tick(Frame_Tick), .Bird_X_L(Bird_X_L),
    .X_Edge_Left(X_Edge_Left), .X_Edge_Right(X_Edge_Right),
    .Y_Edge_Top(Y_Edge_Top), .Y_Edge_Bottom(Y_Edge_Bottom),
    .Cur_Pipe(Cur_Pipe), .Pipe_Sel(Pipe_Sel), .Pipe_X(Pipe_X),
    .Pipe_Gap_Top(Pipe_Gap_Top), .Score_BCD(Score_BCD), .Pass_Pulse(Pass_Pulse)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Advance the model by one clock using the currently driven inputs,
  // then wait for the DUT edge and settle 1 time unit past it.
  task automatic step();
    int nx [NP];
    int ng [NP];
    int ncur, nscore, nlfsr, nmode, npulse, fb, p;
    bit pass, rc;
    nx = m_x; ng = m_g;
    ncur = m_cur; nscore = m_score; nmode = m_mode; npulse = 0;
    fb    = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    nlfsr = ((m_lfsr << 1) & 255) | fb;
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin nx[i] = 400 + 240 * i; ng[i] = 60 + 64 * i; end
      ncur = 0; nscore = 0; nlfsr = 8'hA5; nmode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (Q_Check && !Q_Lose && !Q_Initial) nmode = M_RUN;
        M_RUN:  if (Q_Lose) nmode = M_HOLD;
        M_HOLD: if (Q_Initial && !Q_Lose) nmode = M_LOAD;
        default: nmode = M_IDLE;
      endcase
      if (m_mode == M_LOAD) begin
        for (int i = 0; i < NP; i++) begin nx[i] = 400 + 240 * i; ng[i] = 60 + 64 * i; end
        ncur = 0; nscore = 0;
      end else if (m_mode == M_RUN) begin
        pass = (int'(Bird_X_L) > m_x[m_cur] + 60);
        rc   = 1'b0;
        if (Frame_Tick) begin
          n_ticks++;
          for (int i = 0; i < NP; i++) begin
            if (m_x[i] <= 2) begin
              p = (i + NP - 1) % NP;
              nx[i] = (m_x[p] - 2) + 240;
              ng[i] = 60 + m_lfsr;
              if (i == m_cur) rc = 1'b1;
            end else begin
              nx[i] = m_x[i] - 2;
            end
          end
        end
        if (pass) begin
          nscore = (m_score < 9999) ? m_score + 1 : 9999;
          npulse = 1;
        end
        if (pass || rc) ncur = (m_cur + 1) % NP;
      end
    end
    @(posedge Clk);
    #1;
    m_x = nx; m_g = ng; m_cur = ncur; m_score = nscore;
    m_lfsr = nlfsr; m_mode = nmode; m_pulse = npulse;
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step(); reset = 1'b1;
    total++; if (Cur_Pipe !== 2'd0) begin bad++; $display("FAIL reset_cur: got %0d want 0", Cur_Pipe); end
    total++; if (X_Edge_Left !== 10'd400) begin bad++; $display("FAIL reset_xl: got %0d want 400", X_Edge_Left); end
    total++; if (X_Edge_Right !== 10'd460) begin bad++; $display("FAIL reset_xr: got %0d want 460", X_Edge_Right); end
    total++; if (Y_Edge_Top !== 10'd60) begin bad++; $display("FAIL reset_yt: got %0d want 60", Y_Edge_Top); end
    total++; if (Y_Edge_Bottom !== 10'd180) begin bad++; $display("FAIL reset_yb: got %0d want 180", Y_Edge_Bottom); end
    total++; if (Score_BCD !== 16'h0000) begin bad++; $display("FAIL reset_score: got %h want 0000", Score_BCD); end
    total++; if (Pass_Pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", Pass_Pulse); end
    Pipe_Sel = 2'd2; #1;
    total++; if (Pipe_X !== 10'd880) begin bad++; $display("FAIL reset_px2: got %0d want 880", Pipe_X); end
    total++; if (Pipe_Gap_Top !== 10'd188) begin bad++; $display("FAIL reset_pg2: got %0d want 188", Pipe_Gap_Top); end
    Pipe_Sel = 2'd3; #1;
    total++; if (Pipe_X !== 10'd0) begin bad++; $display("FAIL sel_oor_x: got %0d want 0", Pipe_X); end
    total++; if (Pipe_Gap_Top !== 10'd0) begin bad++; $display("FAIL sel_oor_g: got %0d want 0", Pipe_Gap_Top); end
    Pipe_Sel = 2'd0;
  endtask

  task automatic test_idle_tick();
    for (int c = 0; c < 5; c++) begin
      Frame_Tick = 1'($urandom_range(0, 1)); step(); Frame_Tick = 1'b0;
      total++; if (X_Edge_Left !== 10'd400) begin bad++; $display("FAIL idle_tick_xl: got %0d want 400", X_Edge_Left); end
    end
    // Lose outranks Check, Initial outranks Check: neither leaves IDLE.
    Q_Check = 1'b1; Q_Lose = 1'b1; step(); Q_Lose = 1'b0; Q_Check = 1'b0;
    Frame_Tick = 1'b1; step(); Frame_Tick = 1'b0;
    total++; if (X_Edge_Left !== 10'd400) begin bad++; $display("FAIL prio_lose_xl: got %0d want 400", X_Edge_Left); end
    Q_Check = 1'b1; Q_Initial = 1'b1; step(); Q_Initial = 1'b0; Q_Check = 1'b0;
    Frame_Tick = 1'b1; step(); Frame_Tick = 1'b0;
    total++; if (X_Edge_Left !== 10'd400) begin bad++; $display("FAIL prio_init_xl: got %0d want 400", X_Edge_Left); end
  endtask

  task automatic test_scroll();
    Bird_X_L = 10'd100; n_ticks = 0;
    Q_Check = 1'b1; step(); Q_Check = 1'b0;
    for (int c = 0; c < 1000 && n_ticks < 10; c++) begin
      Frame_Tick = ($urandom_range(0, 2) != 0); step(); Frame_Tick = 1'b0;
      total++; if (X_Edge_Left !== 10'(m_x[m_cur])) begin bad++; $display("FAIL scroll_model_xl: got %0d want %0d", X_Edge_Left, m_x[m_cur]); end
    end
    total++; if (X_Edge_Left !== 10'd380) begin bad++; $display("FAIL scroll_xl: got %0d want 380", X_Edge_Left); end
    Pipe_Sel = 2'd1; #1;
    total++; if (Pipe_X !== 10'd620) begin bad++; $display("FAIL scroll_px1: got %0d want 620", Pipe_X); end
    Pipe_Sel = 2'd0;
  endtask

  task automatic test_pass();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 2000 && n_ticks < 181; c++) begin
      Frame_Tick = ($urandom_range(0, 2) != 0); step(); Frame_Tick = 1'b0;
      if (Pass_Pulse === 1'b1) pulses++;
      total++; if (Pass_Pulse !== 1'(m_pulse)) begin bad++; $display("FAIL pass_model_pulse: got %b want %0d", Pass_Pulse, m_pulse); end
      total++; if (Score_BCD !== to_bcd(m_score)) begin bad++; $display("FAIL pass_model_score: got %h want %h", Score_BCD, to_bcd(m_score)); end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (Pass_Pulse === 1'b1) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL pass_pulse_count: got %0d want 1", pulses); end
    total++; if (Score_BCD !== 16'h0001) begin bad++; $display("FAIL pass_score: got %h want 0001", Score_BCD); end
    total++; if (Cur_Pipe !== 2'd1) begin bad++; $display("FAIL pass_cur: got %0d want 1", Cur_Pipe); end
    total++; if (X_Edge_Left !== 10'd278) begin bad++; $display("FAIL pass_xl: got %0d want 278", X_Edge_Left); end
  endtask

  task automatic test_retire();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 2000 && n_ticks < 200; c++) begin
      Frame_Tick = ($urandom_range(0, 2) != 0); step(); Frame_Tick = 1'b0;
      if (Pass_Pulse === 1'b1) pulses++;
      total++; if (X_Edge_Left !== 10'(m_x[m_cur])) begin bad++; $display("FAIL retire_model_xl: got %0d want %0d", X_Edge_Left, m_x[m_cur]); end
    end
    Pipe_Sel = 2'd0; #1;
    total++; if (Pipe_X !== 10'd720) begin bad++; $display("FAIL retire_px0: got %0d want 720", Pipe_X); end
    total++; if (Pipe_Gap_Top !== 10'(m_g[0])) begin bad++; $display("FAIL retire_gap0: got %0d want %0d", Pipe_Gap_Top, m_g[0]); end
    total++; if (pulses != 0) begin bad++; $display("FAIL retire_pulses: got %0d want 0", pulses); end
    total++; if (Cur_Pipe !== 2'd1) begin bad++; $display("FAIL retire_cur: got %0d want 1", Cur_Pipe); end
  endtask

  task automatic test_lose();
    logic [9:0]  xl0;
    logic [15:0] sc0;
    int held;
    Q_Lose = 1'b1; step(); Q_Lose = 1'b0;
    xl0 = X_Edge_Left; sc0 = Score_BCD; held = 0;
    for (int c = 0; c < 1000 && held < 50; c++) begin
      Frame_Tick = ($urandom_range(0, 2) != 0);
      if (Frame_Tick) held++;
      step(); Frame_Tick = 1'b0;
      total++; if (X_Edge_Left !== xl0) begin bad++; $display("FAIL hold_xl: got %0d want %0d", X_Edge_Left, xl0); end
      total++; if (Score_BCD !== sc0) begin bad++; $display("FAIL hold_score: got %h want %h", Score_BCD, sc0); end
    end
    Q_Initial = 1'b1; Q_Check = 1'b1; step(); Q_Initial = 1'b0;
    total++; if (X_Edge_Left !== xl0) begin bad++; $display("FAIL load_cycle_xl: got %0d want %0d", X_Edge_Left, xl0); end
    step(); Q_Check = 1'b0;
    total++; if (X_Edge_Left !== 10'd400) begin bad++; $display("FAIL load_xl: got %0d want 400", X_Edge_Left); end
    total++; if (Score_BCD !== 16'h0000) begin bad++; $display("FAIL load_score: got %h want 0000", Score_BCD); end
    total++; if (Cur_Pipe !== 2'd0) begin bad++; $display("FAIL load_cur: got %0d want 0", Cur_Pipe); end
    Pipe_Sel = 2'd2; #1;
    total++; if (Pipe_X !== 10'd880) begin bad++; $display("FAIL load_px2: got %0d want 880", Pipe_X); end
    total++; if (Pipe_Gap_Top !== 10'd188) begin bad++; $display("FAIL load_pg2: got %0d want 188", Pipe_Gap_Top); end
    Pipe_Sel = 2'd0;
    Frame_Tick = 1'b1; step(); Frame_Tick = 1'b0;
    total++; if (X_Edge_Left !== 10'd400) begin bad++; $display("FAIL load_check_ignored_xl: got %0d want 400", X_Edge_Left); end
  endtask

  task automatic test_bcd_carry();
    logic [15:0] prev;
    bit saw;
    Bird_X_L = 10'd500;
    Q_Check = 1'b1; step(); Q_Check = 1'b0;
    prev = Score_BCD; saw = 1'b0;
    for (int c = 0; c < 30000 && m_score < 10; c++) begin
      Frame_Tick = ($urandom_range(0, 2) != 0); step(); Frame_Tick = 1'b0;
      total++; if (Score_BCD !== to_bcd(m_score)) begin bad++; $display("FAIL bcd_model_score: got %h want %h", Score_BCD, to_bcd(m_score)); end
      if (prev == 16'h0009 && Score_BCD == 16'h0010) saw = 1'b1;
      prev = Score_BCD;
    end
    total++; if (Score_BCD !== 16'h0010) begin bad++; $display("FAIL bcd_final: got %h want 0010", Score_BCD); end
    total++; if (!saw) begin bad++; $display("FAIL bcd_step_9_to_10: got 0 want 1"); end
  endtask

  task automatic test_reset_pass();
    reset = 1'b0; step(); reset = 1'b1;
    Bird_X_L = 10'd500;
    Q_Check = 1'b1; step(); Q_Check = 1'b0;
    reset = 1'b0; step(); reset = 1'b1;
    total++; if (Score_BCD !== 16'h0000) begin bad++; $display("FAIL rst_pass_score: got %h want 0000", Score_BCD); end
    total++; if (Pass_Pulse !== 1'b0) begin bad++; $display("FAIL rst_pass_pulse: got %b want 0", Pass_Pulse); end
    total++; if (Cur_Pipe !== 2'd0) begin bad++; $display("FAIL rst_pass_cur: got %0d want 0", Cur_Pipe); end
    Q_Check = 1'b1; step(); Q_Check = 1'b0;
    step();
    total++; if (Pass_Pulse !== 1'b1) begin bad++; $display("FAIL run_pass_pulse: got %b want 1", Pass_Pulse); end
    total++; if (Score_BCD !== 16'h0001) begin bad++; $display("FAIL run_pass_score: got %h want 0001", Score_BCD); end
    total++; if (Cur_Pipe !== 2'd1) begin bad++; $display("FAIL run_pass_cur: got %0d want 1", Cur_Pipe); end
    step();
    total++; if (Pass_Pulse !== 1'b0) begin bad++; $display("FAIL run_pass_pulse_drop: got %b want 0", Pass_Pulse); end
  endtask

  initial begin
    test_reset();
    test_idle_tick();
    test_scroll();
    test_pass();
    test_retire();
    test_lose();
    test_bcd_carry();
    test_reset_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
